// File: rtl/matmul_pkg.sv
// Shared definitions for the 3x3 systolic matrix multiplier: array geometry,
// accumulator width, settle time and the result-drain state encoding.
package matmul_pkg;

    localparam int unsigned MM_N      = 3;
    localparam int unsigned MM_W      = 8;
    localparam int unsigned MM_SETTLE = 7;

    typedef enum logic [1:0] {
        DRAIN_IDLE    = 2'd0,
        DRAIN_WAIT    = 2'd1,
        DRAIN_CAPTURE = 2'd2,
        DRAIN_STREAM  = 2'd3
    } drain_state_e;

endpackage

// File: rtl/systolic_result_drain.sv
// Result side of the systolic multiplier: waits out the feed skew, snapshots the
// PE accumulators and streams them row-major over a valid/ready word interface.
module systolic_result_drain
    import matmul_pkg::*;
#(
    parameter int unsigned W      = MM_W,
    parameter int unsigned N      = MM_N,
    parameter int unsigned SETTLE = MM_SETTLE
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [N*N*W-1:0]   acc_in,
    output logic [W-1:0]       out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_last,
    output logic               busy,
    output logic               start_drop
);

    localparam int unsigned WORDS = N * N;
    localparam int unsigned IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int unsigned CNT_W = (SETTLE > 1) ? $clog2(SETTLE + 1) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);
    localparam logic [CNT_W-1:0] CNT_END  = CNT_W'(SETTLE - 1);

    // Settle time shorter than the skewed feed would snapshot partial sums.
    if (SETTLE < 1 || SETTLE < 3 * N - 2) begin : g_settle_chk
        $error("systolic_result_drain: SETTLE must be >= 3*N-2 and >= 1");
    end

    drain_state_e       state;
    logic [CNT_W-1:0]   cnt;
    logic [IDX_W-1:0]   idx;
    logic [W-1:0]       bank [WORDS];

    logic               hs_c;
    logic [IDX_W-1:0]   idx_nxt_c;

    assign hs_c      = out_valid && out_ready;
    assign idx_nxt_c = idx + IDX_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= DRAIN_IDLE;
            cnt        <= '0;
            idx        <= '0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            busy       <= 1'b0;
            start_drop <= 1'b0;
            for (int unsigned k = 0; k < WORDS; k++) begin
                bank[k] <= '0;
            end
        end else begin
            // Any start outside IDLE is discarded and flagged for one cycle.
            start_drop <= start && (state != DRAIN_IDLE);

            case (state)
                DRAIN_IDLE: begin
                    if (start) begin
                        state <= DRAIN_WAIT;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end

                DRAIN_WAIT: begin
                    if (cnt == CNT_END) begin
                        state <= DRAIN_CAPTURE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                DRAIN_CAPTURE: begin
                    for (int unsigned k = 0; k < WORDS; k++) begin
                        bank[k] <= acc_in[k*W +: W];
                    end
                    // Bank is written this edge, so word 0 comes straight from acc_in.
                    idx       <= '0;
                    out_data  <= acc_in[W-1:0];
                    out_valid <= 1'b1;
                    out_last  <= (WORDS == 1);
                    state     <= DRAIN_STREAM;
                end

                DRAIN_STREAM: begin
                    if (hs_c) begin
                        if (idx == LAST_IDX) begin
                            state     <= DRAIN_IDLE;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            out_data  <= '0;
                            busy      <= 1'b0;
                            idx       <= '0;
                        end else begin
                            idx      <= idx_nxt_c;
                            out_data <= bank[idx_nxt_c];
                            out_last <= (idx_nxt_c == LAST_IDX);
                        end
                    end
                end

                default: begin
                    state     <= DRAIN_IDLE;
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_systolic_result_drain.sv
// Self-checking bench for systolic_result_drain: timeline reference model plus
// directed scenarios and a randomized phase.
module tb_systolic_result_drain;
    import matmul_pkg::*;

    localparam int unsigned W     = MM_W;
    localparam int unsigned N     = MM_N;
    localparam int unsigned S     = MM_SETTLE;
    localparam int unsigned WORDS = N * N;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 start = 1'b0;
    logic                 out_ready = 1'b0;
    logic [WORDS*W-1:0]   acc_in = '0;
    logic [W-1:0]         out_data;
    logic                 out_valid;
    logic                 out_last;
    logic                 busy;
    logic                 start_drop;

    systolic_result_drain dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .acc_in     (acc_in),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .busy       (busy),
        .start_drop (start_drop)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a started matrix shows its first word SETTLE+1 edges after
    // the start edge, taken from acc_in as seen at that edge, then pops one word per accept.
    int             m_edge = 0;
    bit             m_busy = 0;
    bit             m_valid = 0;
    bit             m_drop = 0;
    int             m_idx = 0;
    int             m_valid_at = 0;
    bit             m_was_busy;
    logic [W-1:0]   m_words [WORDS];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy  = 0;
            m_valid = 0;
            m_drop  = 0;
            m_idx   = 0;
        end else begin
            m_edge++;
            m_was_busy = m_busy;
            m_drop = start && m_was_busy;
            if (m_valid) begin
                if (out_ready) begin
                    if (m_idx == WORDS - 1) begin
                        m_valid = 0;
                        m_busy  = 0;
                    end else begin
                        m_idx++;
                    end
                end
            end else if (m_busy && m_edge == m_valid_at) begin
                for (int k = 0; k < WORDS; k++) m_words[k] = acc_in[k*W +: W];
                m_valid = 1;
                m_idx   = 0;
            end
            if (start && !m_was_busy) begin
                m_busy     = 1;
                m_valid_at = m_edge + S + 1;
            end
        end
    end

    int drop_cnt = 0;

    always @(negedge clk) begin
        check("busy", busy, m_busy);
        check("out_valid", out_valid, m_valid);
        check("start_drop", start_drop, m_drop);
        if (start_drop) drop_cnt++;
        if (m_valid) begin
            check("out_data", out_data, m_words[m_idx]);
            check("out_last", out_last, (m_idx == WORDS - 1));
        end else begin
            check("out_last_idle", out_last, 0);
            if (!rst_n) check("out_data_rst", out_data, 0);
        end
    end

    logic [W-1:0] got [$];

    always @(posedge clk) begin
        if (rst_n && out_valid && out_ready) got.push_back(out_data);
    end

    logic [W-1:0] cur [WORDS];

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic load_acc();
        for (int k = 0; k < WORDS; k++) acc_in[k*W +: W] = cur[k];
    endtask

    // mode: 0 ready high, 1 ready pattern 1,0,0, 2 random ready.
    task automatic run_matrix(input int mode, input bit poison, input int inject_at,
                              input int abort_at, output int start_edge,
                              output int first_edge, output int end_edge);
        bit injected = 0;
        got.delete();
        load_acc();
        start = 1'b1;
        tick();
        start = 1'b0;
        start_edge = m_edge;
        first_edge = -1;
        end_edge   = -1;
        for (int c = 0; c < 400 && got.size() < WORDS; c++) begin
            if (first_edge < 0 && out_valid) begin
                first_edge = m_edge;
                if (poison) acc_in = '1;
            end
            if (abort_at >= 0 && got.size() == abort_at) begin
                rst_n = 1'b0;
                #1;
                check("abort_valid", out_valid, 0);
                check("abort_busy", busy, 0);
                tick();
                tick();
                rst_n = 1'b1;
                return;
            end
            start = 1'b0;
            if (!injected && inject_at >= 0 && got.size() == inject_at) begin
                start = 1'b1;
                injected = 1;
            end
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (c % 3 == 0);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            tick();
        end
        start = 1'b0;
        end_edge = m_edge;
        if (got.size() < WORDS) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: got %0d words expected %0d", got.size(), WORDS);
        end
        for (int k = 0; k < WORDS && k < got.size(); k++) check("seq_word", got[k], cur[k]);
    endtask

    int se, fe, ee;
    int d0;

    initial begin
        // Reset state
        #3;
        check("rst_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_data", out_data, 0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        check("idle_valid", out_valid, 0);
        check("idle_busy", busy, 0);

        // Single matrix 1..9, ready held high
        for (int k = 0; k < WORDS; k++) cur[k] = W'(k + 1);
        run_matrix(0, 0, -1, -1, se, fe, ee);
        check("first_valid_lat", fe - se, 8);
        check("drain_end_lat", ee - se, 17);
        check("busy_after_drain", busy, 0);
        check("lit_word0", got[0], 1);
        check("lit_word8", got[8], 9);

        // Backpressure
        tick();
        run_matrix(1, 0, -1, -1, se, fe, ee);
        check("bp_count", got.size(), 9);

        // Snapshot isolation: acc_in forced to FF after capture
        tick();
        run_matrix(0, 1, -1, -1, se, fe, ee);
        check("iso_word4", got[4], 5);
        acc_in = '0;

        // Overlap: start mid-stream dropped, then start right after IDLE accepted
        tick();
        d0 = drop_cnt;
        run_matrix(0, 0, 3, -1, se, fe, ee);
        tick();
        check("drop_mid_stream", drop_cnt - d0, 1);
        for (int k = 0; k < WORDS; k++) cur[k] = W'($urandom);
        d0 = drop_cnt;
        run_matrix(0, 0, 8, -1, se, fe, ee);
        tick();
        check("drop_on_last_hs", drop_cnt - d0, 1);
        check("busy_after_last_drop", busy, 0);
        for (int k = 0; k < WORDS; k++) cur[k] = W'($urandom);
        run_matrix(2, 0, -1, -1, se, fe, ee);
        run_matrix(0, 0, -1, -1, se, fe, ee);
        check("restart_next_cycle_lat", fe - se, 8);

        // Reset mid-operation, then fresh matrix starts at word 1
        tick();
        for (int k = 0; k < WORDS; k++) cur[k] = W'(k + 1);
        run_matrix(0, 0, -1, 4, se, fe, ee);
        tick();
        run_matrix(0, 0, -1, -1, se, fe, ee);
        check("post_rst_word0", got[0], 1);

        // Randomized traffic checked by the model every cycle
        for (int i = 0; i < 600; i++) begin
            start     = ($urandom_range(0, 9) == 0);
            out_ready = 1'($urandom_range(0, 1));
            acc_in    = {$urandom, $urandom, $urandom};
            tick();
        end
        start     = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 40; i++) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
